// File: rtl/ram_fifo_wr.sv
// Write-side front end of a RAM-backed FIFO: 2-entry skid buffer, registered RAM write port,
// write/read pointers, reserved and visible occupancy, and empty/full status.
module ram_fifo_wr #(
  parameter int unsigned FIFO_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned AFULL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [FIFO_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [FIFO_WIDTH-1:0] ram_wr_data,
  input  logic                  ram_pop,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  underflow_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfullC = CW'(AFULL_THRESH);

  logic [FIFO_WIDTH-1:0] skid_q [2];
  logic [FIFO_WIDTH-1:0] skid_d [2];
  logic [1:0]            occ_q, occ_d, occ_rem;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rsv_q, rsv_d;
  logic                  underflow_q, underflow_d;

  logic                  accept, drain, pop_ok, pop_bad;
  logic [FIFO_WIDTH-1:0] head;

  always_comb begin
    accept  = in_valid & in_ready_q;
    // An empty skid lets the incoming word pass straight to the RAM write register.
    drain   = ((occ_q != 2'd0) | accept) & (rsv_q != DepthC);
    head    = (occ_q != 2'd0) ? skid_q[0] : in_data;
    pop_ok  = ram_pop & (count_q != '0);
    pop_bad = ram_pop & (count_q == '0);

    skid_d  = skid_q;
    occ_rem = occ_q;
    if (drain && occ_q != 2'd0) begin
      skid_d[0] = skid_q[1];
      occ_rem   = occ_q - 2'd1;
    end
    occ_d = occ_rem;
    if (accept && !(drain && occ_q == 2'd0)) begin
      skid_d[occ_rem[0]] = in_data;
      occ_d              = occ_rem + 2'd1;
    end
    in_ready_d = (occ_d < 2'd2);

    wr_en_d   = drain;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_ptr_d  = wr_ptr_q;
    if (drain) begin
      wr_addr_d = wr_ptr_q;
      wr_data_d = head;
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end

    rd_ptr_d    = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // Reserved count includes the write in flight; visible count lags by the RAM write.
    rsv_d       = rsv_q + CW'(drain) - CW'(pop_ok);
    count_d     = count_q + CW'(wr_en_q) - CW'(pop_ok);
    underflow_d = underflow_q | pop_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsv_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      skid_q[0]   <= skid_d[0];
      skid_q[1]   <= skid_d[1];
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsv_q       <= rsv_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_rd_addr    = rd_ptr_q;
  assign count          = count_q;
  assign underflow_err  = underflow_q;
  assign ram_fifo_empty = (count_q == '0);
  assign fifo_full      = (rsv_q == DepthC);
  assign almost_full    = ((DepthC - rsv_q) <= AfullC);

endmodule

// File: tb/tb_ram_fifo_wr.sv
// Bench for ram_fifo_wr: directed scenarios plus random traffic, all checked each cycle
// against a queue-based transaction model of the FIFO write side.
module tb_ram_fifo_wr;

  localparam int DEPTH = 32;
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, ram_wr_en, ram_pop;
  logic        ram_fifo_empty, fifo_full, almost_full, underflow_err;
  logic [31:0] in_data, ram_wr_data;
  logic [4:0]  ram_wr_addr, ram_rd_addr;
  logic [5:0]  count;

  always #5 clk = ~clk;

  ram_fifo_wr #(
    .FIFO_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .AFULL_THRESH(THRESH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_pop       (ram_pop),
    .ram_rd_addr   (ram_rd_addr),
    .ram_fifo_empty(ram_fifo_empty),
    .fifo_full     (fifo_full),
    .almost_full   (almost_full),
    .count         (count),
    .underflow_err (underflow_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: words waiting upstream of the RAM, the write in flight, and occupancy numbers.
  logic [31:0] m_wait[$];
  bit          m_rdy, m_wr_en, m_uflow;
  logic [31:0] m_wr_data;
  int          m_wr_addr, m_wr_ptr, m_rd_ptr, m_count, m_rsv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_wait.delete();
    m_rdy = 0; m_wr_en = 0; m_uflow = 0; m_wr_data = '0;
    m_wr_addr = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_count = 0; m_rsv = 0;
  endfunction

  function automatic void model_update();
    bit do_pop, drain;
    int new_count;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (in_valid && m_rdy) m_wait.push_back(in_data);
    do_pop = ram_pop && (m_count > 0);
    if (ram_pop && m_count == 0) m_uflow = 1;
    new_count = m_count + (m_wr_en ? 1 : 0) - (do_pop ? 1 : 0);
    drain = (m_wait.size() > 0) && (m_rsv < DEPTH);
    if (drain) begin
      m_wr_data = m_wait.pop_front();
      m_wr_addr = m_wr_ptr;
      m_wr_ptr  = (m_wr_ptr + 1) % DEPTH;
      m_rsv++;
    end
    m_wr_en = drain;
    if (do_pop) begin
      m_rsv--;
      m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
    end
    m_count = new_count;
    m_rdy   = (m_wait.size() < 2);
  endfunction

  task automatic compare_all();
    check("in_ready", in_ready, m_rdy);
    check("wr_en", ram_wr_en, m_wr_en);
    if (m_wr_en) begin
      check("wr_addr", ram_wr_addr, m_wr_addr);
      check("wr_data", ram_wr_data, m_wr_data);
    end
    check("rd_addr", ram_rd_addr, m_rd_ptr);
    check("count", count, m_count);
    check("empty", ram_fifo_empty, m_count == 0);
    check("full", fifo_full, m_rsv == DEPTH);
    check("afull", almost_full, (DEPTH - m_rsv) <= THRESH);
    check("underflow", underflow_err, m_uflow);
  endtask

  // Drive inputs for one cycle, update the model at the edge, compare on the falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic p, input logic r);
    in_valid = v; in_data = d; ram_pop = p; rst_n = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  int n_acc, n_wr, af_at, wraps, prev_addr, next_exp, guard;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ram_pop = 1'b0;
    model_reset();

    // Reset and idle
    repeat (3) step(0, '0, 0, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_wr_data", ram_wr_data, 0);
    check("rst_empty", ram_fifo_empty, 1);
    check("rst_count", count, 0);
    step(0, '0, 0, 1);
    check("rel_in_ready", in_ready, 1);
    repeat (5) step(0, '0, 0, 1);

    // Single word latency
    step(1, 32'hA5A5_0001, 0, 1);
    check("single_wr_en", ram_wr_en, 1);
    check("single_addr", ram_wr_addr, 0);
    check("single_data", ram_wr_data, 32'hA5A5_0001);
    check("single_empty_n1", ram_fifo_empty, 1);
    step(0, '0, 0, 1);
    check("single_empty_n2", ram_fifo_empty, 0);
    check("single_count_n2", count, 1);

    // Fill with no pops
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    n_acc = 0; n_wr = 0; af_at = -1;
    for (int i = 0; i < 40; i++) begin
      bit acc;
      acc = m_rdy;
      step(1, 32'hD000_0000 + n_acc + 1, 0, 1);
      if (acc) n_acc++;
      if (ram_wr_en) n_wr++;
      if (almost_full && af_at < 0) af_at = n_wr;
    end
    check("fill_writes", n_wr, 32);
    check("fill_accepted", n_acc, 34);
    check("fill_af_at", af_at, 28);
    check("fill_full", fifo_full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 32);
    step(0, '0, 1, 1);
    check("fill_pop_count", count, 31);
    step(0, '0, 0, 1);
    check("refill_wr_en", ram_wr_en, 1);
    check("refill_addr", ram_wr_addr, 0);
    check("refill_data", ram_wr_data, 32'hD000_0021);
    step(0, '0, 0, 1);
    check("refill_count", count, 32);

    // Streaming with concurrent pops
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    n_acc = 0; n_wr = 0; wraps = 0; prev_addr = -1; next_exp = 1; guard = 0;
    while ((n_acc < 100 || m_count > 0 || m_wr_en) && guard < 400) begin
      bit acc, v;
      v = (n_acc < 100);
      acc = v && m_rdy;
      step(v, 32'hC000_0000 + n_acc + 1, m_count > 0, 1);
      guard++;
      if (acc) n_acc++;
      if (v && in_ready !== 1'b1) check("stream_rdy", in_ready, 1);
      if (count > 6'd2) check("stream_count_le2", count, 2);
      if (ram_wr_en) begin
        if (ram_wr_data !== 32'hC000_0000 + next_exp) check("stream_order", ram_wr_data,
                                                            32'hC000_0000 + next_exp);
        next_exp++;
        n_wr++;
        if (prev_addr == 31 && ram_wr_addr == 5'd0) wraps++;
        prev_addr = ram_wr_addr;
      end
    end
    check("stream_bound", guard < 400, 1);
    check("stream_writes", n_wr, 100);
    check("stream_wraps", wraps, 3);

    // Underflow
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    step(0, '0, 1, 1);
    check("uflow_set", underflow_err, 1);
    check("uflow_rd_addr", ram_rd_addr, 0);
    step(0, '0, 0, 1);
    check("uflow_sticky", underflow_err, 1);
    step(1, 32'h0000_00AB, 0, 1);
    step(0, '0, 1, 1);
    check("uflow_wr_count", count, 1);
    check("uflow_still", underflow_err, 1);

    // Reset mid-operation
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    for (int i = 0; i < 21; i++) step(1, 32'hE000_0000 + i, 0, 1);
    check("mid_count20", count, 20);
    step(1, 32'hE000_00FF, 0, 0);
    check("mid_wr_en", ram_wr_en, 0);
    check("mid_count", count, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_empty", ram_fifo_empty, 1);
    step(1, 32'hBEEF_0000, 0, 1);
    check("mid_no_wr", ram_wr_en, 0);
    step(1, 32'hBEEF_0001, 0, 1);
    check("mid_next_wr", ram_wr_en, 1);
    check("mid_next_addr", ram_wr_addr, 0);
    check("mid_next_data", ram_wr_data, 32'hBEEF_0001);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < ((i / 500) % 2 ? 7 : 3), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
